// File: rtl/cnn_mac_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cnn_mac_engine                                                  |
// | Purpose  : Multi-channel convolution MAC with bias, saturation and ReLU;   |
// |            results are emitted one channel per handshake.                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module cnn_mac_engine #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 24,
    parameter int TAPS   = 25,
    parameter int NUM_CH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       relu_en,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    input  logic                       w_we,
    input  logic [$clog2(NUM_CH)-1:0]  w_ch,
    input  logic [$clog2(TAPS+1)-1:0]  w_tap,
    input  logic [DATA_W-1:0]          w_data,
    output logic                       w_err,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NUM_CH)-1:0]  out_ch,
    output logic [DATA_W-1:0]          out_data
);

    localparam int c_ch_w   = $clog2(NUM_CH);
    localparam int c_wt_w   = $clog2(TAPS + 1);
    localparam int c_tap_w  = $clog2(TAPS);
    localparam int c_prod_w = 2 * DATA_W;
    localparam int c_acc_w  = 2 * DATA_W + $clog2(TAPS);

    localparam logic [c_tap_w-1:0] c_tap_last = c_tap_w'(TAPS - 1);
    localparam logic [c_wt_w-1:0]  c_bias_sel = c_wt_w'(TAPS);
    localparam logic [c_ch_w-1:0]  c_ch_last  = c_ch_w'(NUM_CH - 1);
    localparam logic [c_ch_w:0]    c_num_ch   = (c_ch_w + 1)'(NUM_CH);
    localparam logic [DATA_W-1:0]  c_max      = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]  c_min      = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_BIAS  = 2'd2,
        ST_EMIT  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Coefficient storage is deliberately left out of reset.
    logic signed [DATA_W-1:0]  r_wgt  [NUM_CH][TAPS];
    logic signed [DATA_W-1:0]  r_bias [NUM_CH];

    logic signed [c_acc_w-1:0] r_acc  [NUM_CH];
    logic [c_tap_w-1:0]        r_tap_cnt;
    logic [c_ch_w-1:0]         r_ch_cnt;
    logic                      r_relu;
    logic                      r_w_err;

    logic                      w_wr_ok;
    logic                      w_sample_acc;
    logic                      w_result_acc;
    logic [c_prod_w-1:0]       w_smp_ext;
    logic signed [c_acc_w-1:0] w_prod_ext [NUM_CH];
    logic signed [c_acc_w-1:0] w_bias_ext [NUM_CH];
    logic [DATA_W-1:0]         w_res      [NUM_CH];

    assign w_wr_ok   = w_we && (r_state == ST_IDLE) &&
                       ({1'b0, w_ch} < c_num_ch) && (w_tap <= c_bias_sel);
    assign w_smp_ext = {{DATA_W{in_data[DATA_W-1]}}, in_data};
    assign w_err     = r_w_err;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            logic [DATA_W-1:0]         w_wgt;
            logic [c_prod_w-1:0]       w_prod;
            logic signed [c_acc_w-1:0] w_sh;
            logic [c_acc_w-DATA_W:0]   w_hi;
            logic [DATA_W-1:0]         w_sat;

            // Low half of the product of the sign-extended operands is the signed product.
            assign w_wgt  = r_wgt[c][r_tap_cnt];
            assign w_prod = w_smp_ext * {{DATA_W{w_wgt[DATA_W-1]}}, w_wgt};
            assign w_prod_ext[c] = {{(c_acc_w-c_prod_w){w_prod[c_prod_w-1]}}, w_prod};
            assign w_bias_ext[c] = {{(c_acc_w-DATA_W-FRAC_W){r_bias[c][DATA_W-1]}},
                                    r_bias[c], {FRAC_W{1'b0}}};

            // In range when every bit above the result MSB matches the sign.
            assign w_sh  = r_acc[c] >>> FRAC_W;
            assign w_hi  = w_sh[c_acc_w-1:DATA_W-1];
            assign w_sat = ((&w_hi) || !(|w_hi)) ? w_sh[DATA_W-1:0]
                         : (w_sh[c_acc_w-1] ? c_min : c_max);
            assign w_res[c] = (r_relu && w_sat[DATA_W-1]) ? '0 : w_sat;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sample_acc = 1'b0;
        w_result_acc = 1'b0;
        busy         = (r_state != ST_IDLE);
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_ch       = '0;
        out_data     = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_sample_acc = 1'b1;
                    if (r_tap_cnt == c_tap_last) begin
                        w_state_nxt = ST_BIAS;
                    end
                end
            end
            ST_BIAS: begin
                w_state_nxt = ST_EMIT;
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                out_ch    = r_ch_cnt;
                out_data  = w_res[r_ch_cnt];
                if (out_ready) begin
                    w_result_acc = 1'b1;
                    if (r_ch_cnt == c_ch_last) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Abort overrides every transition and handshake.
        if (abort) begin
            w_state_nxt  = ST_IDLE;
            w_sample_acc = 1'b0;
            w_result_acc = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_acc[c] <= '0;
            end
            r_tap_cnt <= '0;
            r_ch_cnt  <= '0;
            r_relu    <= 1'b0;
            r_w_err   <= 1'b0;
        end else begin
            r_w_err <= w_we && !w_wr_ok;
            if (abort || ((r_state == ST_IDLE) && start)) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    r_acc[c] <= '0;
                end
                r_tap_cnt <= '0;
                r_ch_cnt  <= '0;
                if (!abort) begin
                    r_relu <= relu_en;
                end
            end else if (w_sample_acc) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    r_acc[c] <= r_acc[c] + w_prod_ext[c];
                end
                r_tap_cnt <= (r_tap_cnt == c_tap_last) ? '0 : r_tap_cnt + c_tap_w'(1);
            end else if (r_state == ST_BIAS) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    r_acc[c] <= r_acc[c] + w_bias_ext[c];
                end
                r_ch_cnt <= '0;
            end else if (w_result_acc) begin
                r_ch_cnt <= (r_ch_cnt == c_ch_last) ? '0 : r_ch_cnt + c_ch_w'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            if (w_tap == c_bias_sel) begin
                r_bias[w_ch] <= w_data;
            end else begin
                r_wgt[w_ch][w_tap[c_tap_w-1:0]] <= w_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cnn_mac_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cnn_mac_engine                                               |
// | Purpose  : Directed and randomised checks of cnn_mac_engine against a      |
// |            wide-integer reference model.                                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_cnn_mac_engine;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 24;
    localparam int TAPS   = 25;
    localparam int NUM_CH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        relu_en = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        w_we = 1'b0;
    logic [1:0]  w_ch = '0;
    logic [4:0]  w_tap = '0;
    logic [31:0] w_data = '0;
    logic        w_err;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_ch;
    logic [31:0] out_data;

    int n_checks = 0;
    int n_errors = 0;

    logic signed [31:0] m_w    [NUM_CH][TAPS];
    logic signed [31:0] m_b    [NUM_CH];
    logic signed [31:0] m_samp [TAPS];
    bit                 m_relu;
    logic [31:0]        outs   [NUM_CH];

    cnn_mac_engine #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .TAPS   (TAPS),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .relu_en   (relu_en),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .w_we      (w_we),
        .w_ch      (w_ch),
        .w_tap     (w_tap),
        .w_data    (w_data),
        .w_err     (w_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Exact convolution in 128-bit integers, then Q-format scaling and clamping.
    function automatic logic [31:0] ref_out(input int c);
        logic signed [127:0] acc, a, b;
        logic signed [127:0] hi_lim, lo_lim;
        logic [31:0]         r;
        hi_lim = 128'sd2147483647;
        lo_lim = -128'sd2147483648;
        acc = '0;
        for (int t = 0; t < TAPS; t++) begin
            a = m_samp[t];
            b = m_w[c][t];
            acc = acc + a * b;
        end
        a = m_b[c];
        acc = acc + a * 128'sd16777216;
        acc = acc >>> FRAC_W;
        if (acc > hi_lim)      r = 32'h7FFFFFFF;
        else if (acc < lo_lim) r = 32'h80000000;
        else                   r = acc[31:0];
        if (m_relu && r[31])   r = '0;
        return r;
    endfunction

    function automatic logic [31:0] rnd_q(input int sh);
        logic signed [31:0] v;
        v = $urandom;
        return v >>> sh;
    endfunction

    task automatic wr(input int ch, input int tap, input logic [31:0] d, input bit exp_err);
        @(negedge clk);
        w_we = 1'b1; w_ch = 2'(ch); w_tap = 5'(tap); w_data = d;
        @(negedge clk);
        w_we = 1'b0;
        check("w_err", w_err, exp_err);
        if (!exp_err) begin
            if (tap == TAPS) m_b[ch] = d;
            else             m_w[ch][tap] = d;
        end
    endtask

    task automatic load_all(input logic [31:0] wv, input logic [31:0] bv);
        for (int c = 0; c < NUM_CH; c++)
            for (int t = 0; t <= TAPS; t++)
                wr(c, t, (t == TAPS) ? bv : wv, 1'b0);
    endtask

    task automatic load_random();
        for (int c = 0; c < NUM_CH; c++)
            for (int t = 0; t <= TAPS; t++)
                wr(c, t, (t == TAPS) ? rnd_q(8) : rnd_q(6), 1'b0);
    endtask

    task automatic do_start(input bit relu);
        @(negedge clk);
        start = 1'b1; relu_en = relu; m_relu = relu;
        @(negedge clk);
        start = 1'b0; relu_en = ~relu;
        check("busy_after_start", busy, 1);
    endtask

    task automatic feed(input int from, input int upto, input int gap);
        int idx = from;
        int cyc = 0;
        while (idx < upto && cyc < 2000) begin
            @(negedge clk); cyc++;
            in_data  = m_samp[idx];
            in_valid = ($urandom_range(0, 99) >= gap);
            if (in_valid && in_ready) idx++;
        end
        check("feed_done", idx, upto);
    endtask

    task automatic collect(input int stall, input bit chk_lat);
        logic [31:0] exp_v [NUM_CH];
        logic [31:0] hd;
        logic [1:0]  hc;
        int ch = 0, cyc = 0, lat = 0;
        bit seen = 0, held = 0, rdy;
        for (int c = 0; c < NUM_CH; c++) exp_v[c] = ref_out(c);
        while (ch < NUM_CH && cyc < 500) begin
            @(negedge clk); cyc++;
            in_valid = 1'b0;
            if (!seen) lat++;
            if (out_valid) begin
                if (!seen) begin
                    seen = 1;
                    if (chk_lat) check("latency", lat, 2);
                end
                if (held) begin
                    check("stall_data", out_data, hd);
                    check("stall_ch", out_ch, hc);
                end
                check("out_ch", out_ch, ch);
                check("out_data", out_data, exp_v[ch]);
                rdy = ($urandom_range(0, 99) >= stall);
                out_ready = rdy;
                if (rdy) begin
                    outs[ch] = out_data; ch++; held = 0;
                end else begin
                    held = 1; hd = out_data; hc = out_ch;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        check("outputs_done", ch, NUM_CH);
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_out_valid", out_valid, 0);
    endtask

    task automatic run_window(input bit relu, input int gap, input int stall);
        do_start(relu);
        feed(0, TAPS, gap);
        collect(stall, gap == 0);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_w_err", w_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unit weights with half-scale samples
        load_all(32'h01000000, 32'h00000000);
        for (int t = 0; t < TAPS; t++) m_samp[t] = 32'h00800000;
        run_window(1'b0, 0, 0);
        for (int c = 0; c < NUM_CH; c++) check("unit_w_12p5", outs[c], 32'h0C800000);

        // Bias only on channel 0, with and without ReLU
        for (int t = 0; t < TAPS; t++) wr(0, t, 32'h0, 1'b0);
        wr(0, TAPS, 32'h00200000, 1'b0);
        for (int t = 0; t < TAPS; t++) m_samp[t] = rnd_q(6);
        run_window(1'b0, 0, 0);
        check("bias_pos", outs[0], 32'h00200000);
        wr(0, TAPS, 32'hFFE00000, 1'b0);
        run_window(1'b1, 0, 0);
        check("bias_neg_relu", outs[0], 32'h00000000);

        // Saturation at both rails
        load_all(32'h7F000000, 32'h00000000);
        for (int t = 0; t < TAPS; t++) m_samp[t] = 32'h7F000000;
        run_window(1'b0, 0, 0);
        for (int c = 0; c < NUM_CH; c++) check("sat_max", outs[c], 32'h7FFFFFFF);
        for (int t = 0; t < TAPS; t++) m_samp[t] = 32'h81000000;
        run_window(1'b0, 0, 0);
        for (int c = 0; c < NUM_CH; c++) check("sat_min", outs[c], 32'h80000000);

        // Random data with valid gaps and ready stalls; first start carries a write
        load_random();
        for (int t = 0; t < TAPS; t++) m_samp[t] = rnd_q(6);
        @(negedge clk);
        start = 1'b1; relu_en = 1'b0; m_relu = 0;
        w_we = 1'b1; w_ch = 2'd1; w_tap = 5'd0; w_data = rnd_q(5);
        m_w[1][0] = w_data;
        @(negedge clk);
        start = 1'b0; w_we = 1'b0;
        check("start_write_err", w_err, 0);
        feed(0, TAPS, 30);
        collect(40, 1'b0);
        for (int k = 0; k < 5; k++) begin
            for (int t = 0; t < TAPS; t++) m_samp[t] = rnd_q(6);
            run_window(1'($urandom_range(0, 1)), 40, 40);
        end

        // Dropped writes and start while busy
        wr(0, 26, 32'hDEADBEEF, 1'b1);
        for (int t = 0; t < TAPS; t++) m_samp[t] = rnd_q(6);
        do_start(1'b0);
        feed(0, 5, 0);
        @(negedge clk);
        in_valid = 1'b0; start = 1'b1;
        w_we = 1'b1; w_ch = 2'd2; w_tap = 5'd3; w_data = 32'h12345678;
        @(negedge clk);
        start = 1'b0; w_we = 1'b0;
        check("busy_write_err", w_err, 1);
        check("busy_still", busy, 1);
        @(negedge clk);
        check("w_err_one_cycle", w_err, 0);
        feed(5, TAPS, 20);
        collect(20, 1'b0);

        // Abort mid-window, then a clean window
        do_start(1'b0);
        feed(0, 10, 0);
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_out", out_valid, 0);
        end
        for (int t = 0; t < TAPS; t++) m_samp[t] = rnd_q(6);
        run_window(1'b1, 25, 25);

        // Asynchronous reset mid-window
        do_start(1'b0);
        feed(0, 8, 0);
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("arst_no_out", out_valid, 0);
        end
        load_random();
        for (int t = 0; t < TAPS; t++) m_samp[t] = rnd_q(6);
        run_window(1'b0, 10, 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
